// File: rtl/lif_decay_update.sv
// ---------------------------------------------------------------------------
// lif_decay_update
//
// Leaky integrate-and-fire membrane update for one neuron sample:
//   v_next = sat(round(v * exp(DECAY_ARG)) + i)
//   spike  = (v_next >= THRESH); on a spike the membrane is forced to V_RESET.
// All values are signed fixed point S1.23.40 (64 bits, 40 fraction bits).
// exp() is computed by an external unit reached through a request/response
// handshake. One transaction is in flight at a time.
//
// Optional build macro:
//   LIF_DECAY_CACHE_EN - the first exp result after reset is kept and reused,
//                        so later transactions skip the exp handshake.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   v_in, i_in                 membrane voltage and current increment
//   in_valid / in_ready        input handshake
//   exp_x                      exp operand (always DECAY_ARG)
//   exp_x_valid / exp_x_ready  exp request handshake
//   exp_y                      exp result (decay factor)
//   exp_y_valid / exp_y_ready  exp result handshake
//   v_out, spike_out           updated membrane voltage and spike flag
//   out_valid / out_ready      output handshake
// ---------------------------------------------------------------------------
module lif_decay_update #(
    parameter logic signed [63:0] DECAY_ARG = 64'hFFFFFFF000000000,
    parameter logic signed [63:0] THRESH    = 64'h0000010000000000,
    parameter logic signed [63:0] V_RESET   = 64'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [63:0] v_in,
    input  logic signed [63:0] i_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [63:0] exp_x,
    output logic               exp_x_valid,
    input  logic               exp_x_ready,
    input  logic signed [63:0] exp_y,
    input  logic               exp_y_valid,
    output logic               exp_y_ready,
    output logic signed [63:0] v_out,
    output logic               spike_out,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int DATA_W = 64;
    localparam int FRAC_W = 40;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [2*DATA_W-1:0]      HALF_LSB =
        {{(2*DATA_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ_EXP,
        WAIT_EXP,
        MULT,
        ADD_CMP,
        DONE
    } state_t;

    // Drop the fraction bits of a full-width product, rounding half up.
    function automatic logic signed [DATA_W-1:0] round_scale(
        input logic signed [2*DATA_W-1:0] prod
    );
        logic [2*DATA_W-1:0] biased;
        biased      = prod + HALF_LSB;
        round_scale = biased[FRAC_W +: DATA_W];
    endfunction

    // Add with one guard bit and clamp to the representable range.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            sat_add = s[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_add = s[DATA_W-1:0];
        end
    endfunction

    state_t                     state_q;
    logic                       in_ready_q;
    logic signed [DATA_W-1:0]   exp_x_q;
    logic                       exp_x_valid_q;
    logic                       exp_y_ready_q;
    logic signed [DATA_W-1:0]   v_out_q;
    logic                       spike_q;
    logic                       out_valid_q;
    logic signed [DATA_W-1:0]   v_q;
    logic signed [DATA_W-1:0]   i_q;
    logic signed [DATA_W-1:0]   decay_q;
    logic signed [DATA_W-1:0]   scaled_q;

    logic signed [2*DATA_W-1:0] prod_d;
    logic signed [DATA_W-1:0]   scaled_d;
    logic signed [DATA_W-1:0]   sum_d;
    logic                       cache_hit;

`ifdef LIF_DECAY_CACHE_EN
    logic cache_vld_q;
    assign cache_hit = cache_vld_q;
`else
    assign cache_hit = 1'b0;
`endif

    // MULT stage: full-precision signed product, then back to S1.23.40.
    // ADD_CMP stage: saturating add of the current increment.
    always_comb begin
        prod_d   = $signed({{DATA_W{v_q[DATA_W-1]}}, v_q}) *
                   $signed({{DATA_W{decay_q[DATA_W-1]}}, decay_q});
        scaled_d = round_scale(prod_d);
        sum_d    = sat_add(scaled_q, i_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b1;
            exp_x_q       <= '0;
            exp_x_valid_q <= 1'b0;
            exp_y_ready_q <= 1'b0;
            v_out_q       <= '0;
            spike_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            v_q           <= '0;
            i_q           <= '0;
            decay_q       <= '0;
            scaled_q      <= '0;
`ifdef LIF_DECAY_CACHE_EN
            cache_vld_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        v_q        <= v_in;
                        i_q        <= i_in;
                        in_ready_q <= 1'b0;
                        if (cache_hit) begin
                            state_q <= MULT;
                        end else begin
                            exp_x_q       <= DECAY_ARG;
                            exp_x_valid_q <= 1'b1;
                            state_q       <= REQ_EXP;
                        end
                    end
                end
                REQ_EXP: begin
                    if (exp_x_ready) begin
                        exp_x_valid_q <= 1'b0;
                        exp_y_ready_q <= 1'b1;
                        state_q       <= WAIT_EXP;
                    end
                end
                WAIT_EXP: begin
                    if (exp_y_valid) begin
                        decay_q       <= exp_y;
                        exp_y_ready_q <= 1'b0;
`ifdef LIF_DECAY_CACHE_EN
                        cache_vld_q   <= 1'b1;
`endif
                        state_q       <= MULT;
                    end
                end
                MULT: begin
                    scaled_q <= scaled_d;
                    state_q  <= ADD_CMP;
                end
                ADD_CMP: begin
                    if (sum_d >= THRESH) begin
                        spike_q <= 1'b1;
                        v_out_q <= V_RESET;
                    end else begin
                        spike_q <= 1'b0;
                        v_out_q <= sum_d;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign exp_x       = exp_x_q;
    assign exp_x_valid = exp_x_valid_q;
    assign exp_y_ready = exp_y_ready_q;
    assign v_out       = v_out_q;
    assign spike_out   = spike_q;
    assign out_valid   = out_valid_q;

endmodule

// File: doc/lif_decay_update.md
LIF_DECAY_UPDATE -- requirements
Module: lif_decay_update

Interface
REQ-001 Parameter DECAY_ARG, default 64'hFFFFFFF000000000 (-0.0625), meaning -dt/tau in S1.23.40, sent to the exp unit.
REQ-002 Parameter THRESH, default 64'h0000010000000000 (1.0), meaning the spike threshold in S1.23.40.
REQ-003 Parameter V_RESET, default 64'd0, meaning the post-spike membrane value in S1.23.40.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 v_in  in  64  signed membrane voltage, S1.23.40.
REQ-008 i_in  in  64  signed input current increment, S1.23.40.
REQ-009 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-010 exp_x  out  64  exp unit operand, S1.23.40.
REQ-011 exp_x_valid / exp_x_ready  out / in  1 / 1  exp request handshake.
REQ-012 exp_y  in  64  exp unit result, S1.23.40.
REQ-013 exp_y_valid / exp_y_ready  in / out  1 / 1  exp result handshake.
REQ-014 v_out  out  64  signed updated membrane voltage, S1.23.40.
REQ-015 spike_out  out  1  high when the update crossed THRESH.
REQ-016 out_valid / out_ready  out / in  1 / 1  output handshake.

Function
REQ-017 FSM states: IDLE, REQ_EXP, WAIT_EXP, MULT, ADD_CMP, DONE.
REQ-018 IDLE: in_ready=1; on in_valid&&in_ready, capture v_in and i_in, drop in_ready, go to REQ_EXP (or MULT on cache hit, REQ-032).
REQ-019 REQ_EXP: exp_x=DECAY_ARG, exp_x_valid=1, held stable until exp_x_ready; on handshake go to WAIT_EXP with exp_x_valid=0.
REQ-020 WAIT_EXP: exp_y_ready=1; on exp_y_valid capture exp_y as decay and go to MULT; exp_y_ready=0 in all other states, where exp_y_valid is ignored.
REQ-021 MULT: 128-bit signed product v*decay; scaled result = (product + 2^39) >>> 40 (round half up), truncated to 64 bits.
REQ-022 ADD_CMP: sum = scaled + i (65-bit internal), saturated to [0x8000000000000000, 0x7FFFFFFFFFFFFFFF].
REQ-023 ADD_CMP: if saturated sum >= THRESH (signed compare), spike_out=1 and v_out=V_RESET; else spike_out=0 and v_out=sum; go to DONE.
REQ-024 DONE: out_valid=1; v_out and spike_out held stable until out_ready; on handshake out_valid=0 and go to IDLE.
REQ-025 Latency, peers always ready: accept at cycle T, exp_x_valid at T+1; exp_y handshake at cycle E gives out_valid at E+3.
REQ-026 in_ready SHALL stay 0 from acceptance until the output handshake completes; only one transaction is in flight.

Reset
REQ-027 Reset SHALL force state IDLE from any state, mid-transaction included, with no output handshake for the aborted transaction.
REQ-028 Reset values: in_ready=1, exp_x=0, exp_x_valid=0, exp_y_ready=0, v_out=0, spike_out=0, out_valid=0; internal registers and cache valid flag 0.
REQ-029 The first in_valid after rst_n deasserts SHALL be accepted in IDLE normally.

Configuration
REQ-030 Macro LIF_DECAY_CACHE_EN selects decay caching.
REQ-031 Without LIF_DECAY_CACHE_EN, every transaction performs one exp request/response.
REQ-032 With LIF_DECAY_CACHE_EN:
- First transaction after reset requests exp and stores exp_y plus a valid flag.
- Later transactions go IDLE->MULT using the cached decay, with no exp handshake.
- out_valid at T+3.

Verification
REQ-033 Reset mid-WAIT_EXP -> all outputs at REQ-028 values next cycle; in_ready=1.
REQ-034 v_in=64'h0000010000000000, i_in=0, stub exp_y=64'h0000008000000000 -> exp_x=DECAY_ARG; v_out=64'h0000008000000000, spike_out=0.
REQ-035 v_in=64'h0000010000000000, i_in=64'h000000C000000000, exp_y=0.5 -> sum 1.25; spike_out=1, v_out=0.
REQ-036 v_in=64'h7FFFFFFFFFFFFFFF, exp_y=64'h0000010000000000, i_in=64'h0000010000000000 -> sum saturates; spike_out=1, v_out=0.
REQ-037 out_ready held 0 for 5 cycles in DONE -> out_valid=1, v_out/spike_out unchanged, in_ready=0 throughout.
REQ-038 Two back-to-back transactions -> exp_x_valid pulses twice without the macro and once with LIF_DECAY_CACHE_EN; v_out is identical in both builds.
